hazard_scoreboard: RTL and testbench
====================================

Name: hazard_scoreboard

Overview:
- Parametrised, stateful load-use/RAW hazard unit for the 5-stage RV32I pipeline; sits in ID beside the decoder and drives PC, IF/ID and ID/EX controls.
- Replaces pure EX/MEM destination compares with a per-register countdown scoreboard.
- Supports non-forwarding and forwarding pipelines (load-use only) from one RTL source.
- Honours whole-pipeline freeze (memory wait states) and branch squash of the ID instruction.

Parameters:
- NUM_REGS, 32: architectural registers tracked; x0 never tracked.
- REG_AW, 5: register index width, equal to clog2(NUM_REGS).
- FWD_MODE, 0: 0 = non-forwarding pipeline; 1 = full forwarding, so only loads create a hazard.
- WB_DIST, 2: bubbles needed after any writer in non-forwarding mode. The producer must leave EX and MEM before a consumer leaves ID.
- LOAD_LAT, 1: bubbles needed after a load in forwarding mode.
- CNT_W, 2: counter width, at least clog2(max(WB_DIST, LOAD_LAT)+1).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- id_valid_i  in  1  ID holds a real (non-bubble) instruction
- rs1_id_i  in  REG_AW  ID source 1
- rs2_id_i  in  REG_AW  ID source 2
- uses_rs1_i  in  1  ID instruction consumes rs1
- uses_rs2_i  in  1  ID instruction consumes rs2
- rd_id_i  in  REG_AW  ID destination
- regwen_id_i  in  1  ID instruction writes rd
- is_load_id_i  in  1  ID instruction is a load
- freeze_i  in  1  global pipeline freeze (D-mem/I-mem wait)
- flush_i  in  1  branch/jump redirect; the ID instruction is squashed this cycle
- hazard_o  out  1  RAW hazard detected on the current ID instruction
- pc_en_o  out  1  PC write enable
- if_id_en_o  out  1  IF/ID register enable
- id_ex_flush_o  out  1  insert bubble into ID/EX
- busy_o  out  1  some scoreboard counter is nonzero

Behaviour:
- State: cnt[r], CNT_W bits, for r = 1..NUM_REGS-1. Reset clears all to 0 asynchronously on rst_ni low. cnt[0] is constant 0.
- Combinational hazard: hazard_o = id_valid_i & ((uses_rs1_i & rs1_id_i != 0 & cnt[rs1_id_i] != 0) | (uses_rs2_i & rs2_id_i != 0 & cnt[rs2_id_i] != 0)).
- Output priority, evaluated combinationally each cycle:
  - flush_i: pc_en_o = 1, if_id_en_o = 1, id_ex_flush_o = 1. Redirect wins over hazard and over freeze.
  - else freeze_i: pc_en_o = 0, if_id_en_o = 0, id_ex_flush_o = 0. Hold, with no bubble.
  - else hazard_o: pc_en_o = 0, if_id_en_o = 0, id_ex_flush_o = 1.
  - else: pc_en_o = 1, if_id_en_o = 1, id_ex_flush_o = 0.
- During reset, outputs follow the same equations with all cnt = 0, so there is no spurious stall.
- issue = id_valid_i & ~hazard_o & ~freeze_i & ~flush_i.
- Issue latency value lat:
  - FWD_MODE = 0: lat = WB_DIST for any writer.
  - FWD_MODE = 1: lat = is_load_id_i ? LOAD_LAT : 0.
- Per-cycle update, clocked:
  - If freeze_i is high, all counters hold.
  - Otherwise each nonzero cnt decrements by 1. Then, if issue & regwen_id_i & rd_id_i != 0, cnt[rd_id_i] is set to lat. The issue write overrides the decrement on the same register, and lat = 0 clears it (WAW by a younger ALU op under forwarding).
- Counters never wrap; decrement saturates at 0.
- Stall length: a consumer immediately behind a producer sees exactly lat bubbles, plus any freeze cycles.
- A hazard stall does not block counter decrement, so a stall always resolves.
- busy_o = OR of all counters, registered view (no lookahead).
- Reset mid-stall: all counters clear immediately and the pipeline resumes next cycle.

Optional Feature:
- Macro HAZARD_STALL_CNT_EN.
- When defined:
  - Adds output stall_cycles_o, 32 bits: count of cycles with hazard_o = 1 & ~freeze_i & ~flush_i.
  - Saturates at 0xFFFFFFFF; reset to 0.
  - Adds input stall_cnt_clr_i, 1 bit, a synchronous clear that wins over increment.
- When undefined: neither port exists and no counter logic is present.

Test Plan:
- FWD_MODE = 0: issue addi x5 (rd = 5, regwen = 1), then add x6,x5,x0 (rs1 = 5) the next cycle -> hazard_o = 1 and id_ex_flush_o = 1 for exactly 2 cycles, then the consumer issues and cnt[5] = 0 afterwards.
- FWD_MODE = 1: lw x7 (is_load = 1) followed by use of x7 -> exactly 1 bubble. ALU write of x8 followed by use of x8 -> 0 bubbles.
- Writer rd = 0 followed by consumer rs1 = 0 -> no hazard; uses_rs2_i = 0 with a matching rs2 -> no hazard.
- Pending cnt[5] = 2, freeze_i held 3 cycles -> cnt[5] stays 2, outputs hold with id_ex_flush_o = 0; after release, 2 more stall cycles.
- Hazard pending with flush_i = 1 in the same cycle -> pc_en_o = 1, if_id_en_o = 1, id_ex_flush_o = 1, no scoreboard write for the squashed instruction.
- rst_ni driven low while cnt[3] = 2 -> all counters 0 asynchronously and busy_o = 0. With HAZARD_STALL_CNT_EN defined, stall_cycles_o = 0 after reset and counts 2 after the first test's stall.

Source files
------------

// File: rtl/hazard_scoreboard_if.sv
// ID-stage hazard handshake: decoded operand info in, pipeline stall/bubble controls out.
// master = decode/pipeline side, slave = hazard_scoreboard.
interface hazard_scoreboard_if #(
  parameter int REG_AW = 5
);
  logic              id_valid_i;
  logic [REG_AW-1:0] rs1_id_i;
  logic [REG_AW-1:0] rs2_id_i;
  logic              uses_rs1_i;
  logic              uses_rs2_i;
  logic [REG_AW-1:0] rd_id_i;
  logic              regwen_id_i;
  logic              is_load_id_i;
  logic              freeze_i;
  logic              flush_i;
  logic              hazard_o;
  logic              pc_en_o;
  logic              if_id_en_o;
  logic              id_ex_flush_o;
  logic              busy_o;

  modport master (
    output id_valid_i, rs1_id_i, rs2_id_i, uses_rs1_i, uses_rs2_i,
           rd_id_i, regwen_id_i, is_load_id_i, freeze_i, flush_i,
    input  hazard_o, pc_en_o, if_id_en_o, id_ex_flush_o, busy_o
  );

  modport slave (
    input  id_valid_i, rs1_id_i, rs2_id_i, uses_rs1_i, uses_rs2_i,
           rd_id_i, regwen_id_i, is_load_id_i, freeze_i, flush_i,
    output hazard_o, pc_en_o, if_id_en_o, id_ex_flush_o, busy_o
  );
endinterface

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard for RAW / load-use stalls in the ID stage.
// Optional stall-cycle counter enabled by defining HAZARD_STALL_CNT_EN.

module hazard_cnt_cell #(
  parameter int CNT_W = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             hold,
  input  logic             set,
  input  logic [CNT_W-1:0] lat,
  output logic [CNT_W-1:0] cnt
);
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)            cnt <= '0;
    else if (!hold) begin
      if (set)              cnt <= lat;
      else if (cnt != '0)   cnt <= cnt - 1'b1;
    end
  end
endmodule

module hazard_scoreboard #(
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = 5,
  parameter int FWD_MODE = 0,
  parameter int WB_DIST  = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  hazard_scoreboard_if.slave hz
`ifdef HAZARD_STALL_CNT_EN
  ,
  input  logic        stall_cnt_clr_i,
  output logic [31:0] stall_cycles_o
`endif
);
  localparam logic [CNT_W-1:0] WB_LAT = CNT_W'(WB_DIST);
  localparam logic [CNT_W-1:0] LD_LAT = CNT_W'(LOAD_LAT);

  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic [CNT_W-1:0]               lat;
  logic                           hazard;
  logic                           issue;
  logic                           wr_en;

  assign cnt[0] = '0;

  assign hazard = hz.id_valid_i &
                  ((hz.uses_rs1_i & (hz.rs1_id_i != '0) & (cnt[hz.rs1_id_i] != '0)) |
                   (hz.uses_rs2_i & (hz.rs2_id_i != '0) & (cnt[hz.rs2_id_i] != '0)));

  assign issue = hz.id_valid_i & ~hazard & ~hz.freeze_i & ~hz.flush_i;
  assign wr_en = issue & hz.regwen_id_i & (hz.rd_id_i != '0);

  // Under forwarding only loads need bubbles; an ALU write (lat 0) clears a stale load entry.
  always_comb begin
    lat = WB_LAT;
    if (FWD_MODE != 0) lat = hz.is_load_id_i ? LD_LAT : '0;
  end

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    hazard_cnt_cell #(.CNT_W(CNT_W)) u_cell (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .hold   (hz.freeze_i),
      .set    (wr_en & (hz.rd_id_i == REG_AW'(r))),
      .lat    (lat),
      .cnt    (cnt[r])
    );
  end

  // Redirect beats freeze, freeze beats hazard; a frozen stall must not inject a bubble.
  always_comb begin
    hz.pc_en_o       = 1'b1;
    hz.if_id_en_o    = 1'b1;
    hz.id_ex_flush_o = 1'b0;
    if (hz.flush_i) begin
      hz.id_ex_flush_o = 1'b1;
    end else if (hz.freeze_i) begin
      hz.pc_en_o       = 1'b0;
      hz.if_id_en_o    = 1'b0;
    end else if (hazard) begin
      hz.pc_en_o       = 1'b0;
      hz.if_id_en_o    = 1'b0;
      hz.id_ex_flush_o = 1'b1;
    end
  end

  assign hz.hazard_o = hazard;
  assign hz.busy_o   = |cnt;

`ifdef HAZARD_STALL_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      stall_cycles_o <= '0;
    else if (stall_cnt_clr_i)
      stall_cycles_o <= '0;
    else if (hazard & ~hz.freeze_i & ~hz.flush_i & (stall_cycles_o != '1))
      stall_cycles_o <= stall_cycles_o + 32'd1;
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench: dut0 is the non-forwarding build, dut1 the forwarding build, same stimulus.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  logic       v, u1, u2, wen, ld, frz, fl;
  logic [4:0] rs1, rs2, rd;

  hazard_scoreboard_if #(.REG_AW(5)) if0 ();
  hazard_scoreboard_if #(.REG_AW(5)) if1 ();

  assign if0.id_valid_i = v;   assign if1.id_valid_i = v;
  assign if0.rs1_id_i = rs1;   assign if1.rs1_id_i = rs1;
  assign if0.rs2_id_i = rs2;   assign if1.rs2_id_i = rs2;
  assign if0.uses_rs1_i = u1;  assign if1.uses_rs1_i = u1;
  assign if0.uses_rs2_i = u2;  assign if1.uses_rs2_i = u2;
  assign if0.rd_id_i = rd;     assign if1.rd_id_i = rd;
  assign if0.regwen_id_i = wen; assign if1.regwen_id_i = wen;
  assign if0.is_load_id_i = ld; assign if1.is_load_id_i = ld;
  assign if0.freeze_i = frz;   assign if1.freeze_i = frz;
  assign if0.flush_i = fl;     assign if1.flush_i = fl;

`ifdef HAZARD_STALL_CNT_EN
  logic        clr;
  logic [31:0] sc0, sc1;
`endif

  hazard_scoreboard #(.FWD_MODE(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n), .hz(if0)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt_clr_i(clr), .stall_cycles_o(sc0)
`endif
  );

  hazard_scoreboard #(.FWD_MODE(1)) dut1 (
    .clk_i(clk), .rst_ni(rst_n), .hz(if1)
`ifdef HAZARD_STALL_CNT_EN
    , .stall_cnt_clr_i(clr), .stall_cycles_o(sc1)
`endif
  );

  always #5 clk = ~clk;

  task automatic drive(input logic iv, input logic [4:0] irs1, input logic iu1,
                       input logic [4:0] irs2, input logic iu2, input logic [4:0] ird,
                       input logic iwen, input logic ild, input logic ifrz, input logic ifl);
    v = iv; rs1 = irs1; u1 = iu1; rs2 = irs2; u2 = iu2; rd = ird;
    wen = iwen; ld = ild; frz = ifrz; fl = ifl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic test_reset();
    drive(1, 5, 1, 6, 1, 7, 1, 0, 0, 0);
    checks++;
    if (if0.hazard_o !== 1'b0 || if0.pc_en_o !== 1'b1 || if0.if_id_en_o !== 1'b1 ||
        if0.id_ex_flush_o !== 1'b0 || if0.busy_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got haz=%b pc=%b ifid=%b flush=%b busy=%b want 0 1 1 0 0",
               if0.hazard_o, if0.pc_en_o, if0.if_id_en_o, if0.id_ex_flush_o, if0.busy_o);
    end
`ifdef HAZARD_STALL_CNT_EN
    checks++;
    if (sc0 !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt: got %0d want 0", sc0); end
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_raw_nofwd();
    int n;
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);   // addi x5
    checks++;
    if (if0.hazard_o !== 1'b0) begin errors++; $display("FAIL raw_producer_haz: got %b want 0", if0.hazard_o); end
    tick();
    drive(1, 5, 1, 0, 1, 6, 0, 0, 0, 0);   // add x6,x5,x0 (regwen held low to watch busy)
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (if0.hazard_o !== 1'b1) break;
      n++;
      checks++;
      if (if0.id_ex_flush_o !== 1'b1 || if0.pc_en_o !== 1'b0 || if0.if_id_en_o !== 1'b0) begin
        errors++;
        $display("FAIL raw_stall_ctl: got flush=%b pc=%b ifid=%b want 1 0 0",
                 if0.id_ex_flush_o, if0.pc_en_o, if0.if_id_en_o);
      end
      tick();
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL raw_bubbles: got %0d want 2", n); end
    checks++;
    if (if0.id_ex_flush_o !== 1'b0 || if0.pc_en_o !== 1'b1) begin
      errors++; $display("FAIL raw_issue: got flush=%b pc=%b want 0 1", if0.id_ex_flush_o, if0.pc_en_o);
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (if0.busy_o !== 1'b0) begin errors++; $display("FAIL raw_cnt_clear: busy got %b want 0", if0.busy_o); end
`ifdef HAZARD_STALL_CNT_EN
    checks++;
    if (sc0 !== 32'd2) begin errors++; $display("FAIL stall_cnt_after_raw: got %0d want 2", sc0); end
    clr = 1'b1; tick(); clr = 1'b0; #1;
    checks++;
    if (sc0 !== 32'd0) begin errors++; $display("FAIL stall_cnt_clear: got %0d want 0", sc0); end
`endif
    idle(3);
  endtask

  task automatic test_fwd();
    int n;
    drive(1, 0, 0, 0, 0, 7, 1, 1, 0, 0);   // lw x7
    tick();
    drive(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (if1.hazard_o !== 1'b1) break;
      n++; tick();
    end
    checks++;
    if (n != 1) begin errors++; $display("FAIL fwd_load_bubbles: got %0d want 1", n); end
    tick();
    drive(1, 0, 0, 0, 0, 8, 1, 0, 0, 0);   // ALU write x8
    tick();
    drive(1, 0, 0, 8, 1, 0, 0, 0, 0, 0);
    checks++;
    if (if1.hazard_o !== 1'b0 || if1.id_ex_flush_o !== 1'b0) begin
      errors++; $display("FAIL fwd_alu_bubbles: got haz=%b flush=%b want 0 0", if1.hazard_o, if1.id_ex_flush_o);
    end
    idle(3);
  endtask

  task automatic test_x0_and_unused();
    drive(1, 0, 0, 0, 0, 0, 1, 0, 0, 0);   // writer rd=x0
    tick();
    drive(1, 0, 1, 0, 1, 0, 0, 0, 0, 0);
    checks++;
    if (if0.hazard_o !== 1'b0 || if0.busy_o !== 1'b0) begin
      errors++; $display("FAIL x0_hazard: got haz=%b busy=%b want 0 0", if0.hazard_o, if0.busy_o);
    end
    tick();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 0, 0);   // writer x9
    tick();
    drive(1, 9, 0, 9, 0, 0, 0, 0, 0, 0);   // matching sources but unused
    checks++;
    if (if0.hazard_o !== 1'b0) begin errors++; $display("FAIL unused_src_hazard: got %b want 0", if0.hazard_o); end
    drive(0, 9, 1, 9, 1, 0, 0, 0, 0, 0);   // bubble in ID never stalls
    checks++;
    if (if0.hazard_o !== 1'b0) begin errors++; $display("FAIL invalid_id_hazard: got %b want 0", if0.hazard_o); end
    idle(3);
  endtask

  task automatic test_freeze();
    int n;
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 0, 0, 0, 1, 0);
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (if0.pc_en_o !== 1'b0 || if0.if_id_en_o !== 1'b0 || if0.id_ex_flush_o !== 1'b0 ||
          if0.busy_o !== 1'b1) begin
        errors++;
        $display("FAIL freeze_hold: got pc=%b ifid=%b flush=%b busy=%b want 0 0 0 1",
                 if0.pc_en_o, if0.if_id_en_o, if0.id_ex_flush_o, if0.busy_o);
      end
      tick();
    end
    frz = 1'b0; #1;
    n = 0;
    for (int k = 0; k < 8; k++) begin
      if (if0.hazard_o !== 1'b1) break;
      n++; tick();
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL freeze_post_bubbles: got %0d want 2", n); end
    idle(3);
  endtask

  task automatic test_flush();
    drive(1, 0, 0, 0, 0, 5, 1, 0, 0, 0);
    tick();
    drive(1, 5, 1, 0, 0, 10, 1, 0, 0, 1);  // hazard + redirect
    checks++;
    if (if0.hazard_o !== 1'b1 || if0.pc_en_o !== 1'b1 || if0.if_id_en_o !== 1'b1 ||
        if0.id_ex_flush_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_priority: got haz=%b pc=%b ifid=%b flush=%b want 1 1 1 1",
               if0.hazard_o, if0.pc_en_o, if0.if_id_en_o, if0.id_ex_flush_o);
    end
    tick();
    drive(1, 10, 1, 0, 0, 11, 1, 0, 1, 1);  // redirect also beats freeze
    checks++;
    if (if0.pc_en_o !== 1'b1 || if0.if_id_en_o !== 1'b1 || if0.id_ex_flush_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_over_freeze: got pc=%b ifid=%b flush=%b want 1 1 1",
               if0.pc_en_o, if0.if_id_en_o, if0.id_ex_flush_o);
    end
    checks++;
    if (if0.hazard_o !== 1'b0) begin errors++; $display("FAIL flush_no_write_haz: got %b want 0", if0.hazard_o); end
    tick();
    drive(1, 0, 0, 0, 0, 11, 1, 0, 0, 1);  // squashed writer without hazard
    tick();
    drive(1, 11, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (if0.hazard_o !== 1'b0) begin errors++; $display("FAIL flush_squash_write: got haz=%b want 0", if0.hazard_o); end
    idle(3);
  endtask

  task automatic test_reset_midstall();
    drive(1, 0, 0, 0, 0, 3, 1, 0, 0, 0);
    tick();
    drive(1, 3, 1, 0, 0, 0, 0, 0, 0, 0);
    checks++;
    if (if0.hazard_o !== 1'b1) begin errors++; $display("FAIL midstall_pre_haz: got %b want 1", if0.hazard_o); end
    #1 rst_n = 1'b0; #1;
    checks++;
    if (if0.busy_o !== 1'b0 || if0.hazard_o !== 1'b0 || if0.pc_en_o !== 1'b1) begin
      errors++;
      $display("FAIL midstall_reset: got busy=%b haz=%b pc=%b want 0 0 1", if0.busy_o, if0.hazard_o, if0.pc_en_o);
    end
    tick();
    #1 rst_n = 1'b1;
    tick();
    checks++;
    if (if0.hazard_o !== 1'b0 || if0.id_ex_flush_o !== 1'b0) begin
      errors++; $display("FAIL midstall_resume: got haz=%b flush=%b want 0 0", if0.hazard_o, if0.id_ex_flush_o);
    end
`ifdef HAZARD_STALL_CNT_EN
    checks++;
    if (sc0 !== 32'd0) begin errors++; $display("FAIL midstall_stall_cnt: got %0d want 0", sc0); end
`endif
    idle(2);
  endtask

  initial begin
`ifdef HAZARD_STALL_CNT_EN
    clr = 1'b0;
`endif
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    test_reset();
    test_raw_nofwd();
    test_fwd();
    test_x0_and_unused();
    test_freeze();
    test_flush();
    test_reset_midstall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
